// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH clock dividers on clk_sys; shadowed half-period updates land only on phase boundaries.
// Latency: clk_out/tick/cfg_pending are registered; first rise comes act+1 cycles after a channel starts.
// No backpressure: cfg_wr is always accepted. Define CLKDIV_BANK_TICK_EN to build the rise-tick registers.
module clock_divider_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int RESET_HALF = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] act_q   [NUM_CH];
  logic [CNT_W-1:0] act_d   [NUM_CH];
  logic [CNT_W-1:0] shd_q   [NUM_CH];
  logic [CNT_W-1:0] shd_d   [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] boundary, wr_hit, apply;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        act_q[i]   <= CNT_W'(RESET_HALF);
        shd_q[i]   <= CNT_W'(RESET_HALF);
      end
      clk_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        act_q[i]   <= act_d[i];
        shd_q[i]   <= shd_d[i];
      end
      clk_q  <= clk_d;
      pend_q <= pend_d;
    end
  end

  // Out-of-range channel indices never match, so such writes fall away here.
  always_comb begin
    boundary = '0;
    wr_hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      boundary[i] = (cnt_q[i] == act_q[i]);
      wr_hit[i]   = cfg_wr && (32'(cfg_ch) == i);
    end
  end

  always_comb begin
    clk_d  = clk_q;
    pend_d = pend_q;
    apply  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      act_d[i]   = act_q[i];
      shd_d[i]   = shd_q[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
          if (ch_en[i]) state_d[i] = RUN;
        end
        RUN: begin
          if (sync) begin
            cnt_d[i]   = '0;
            clk_d[i]   = 1'b0;
            apply[i]   = 1'b1;
            state_d[i] = ch_en[i] ? RUN : IDLE;
          end else if (!ch_en[i] && !clk_q[i]) begin
            cnt_d[i]   = '0;
            apply[i]   = 1'b1;
            state_d[i] = IDLE;
          end else if (boundary[i]) begin
            // Disabled with clk_out high and already at the edge: fall and stop now.
            cnt_d[i] = '0;
            clk_d[i] = ~clk_q[i];
            apply[i] = 1'b1;
            if (!ch_en[i]) state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (!ch_en[i]) state_d[i] = DRAIN;
          end
        end
        DRAIN: begin
          if (boundary[i]) begin
            cnt_d[i]   = '0;
            clk_d[i]   = 1'b0;
            apply[i]   = 1'b1;
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // Apply uses the registered pending flag, so a same-cycle write stays pending.
      if (apply[i] && pend_q[i]) begin
        act_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
      end
      if (wr_hit[i]) begin
        shd_d[i]  = cfg_half;
        pend_d[i] = 1'b1;
      end
    end
  end

  assign clk_out     = clk_q;
  assign cfg_pending = pend_q;

`ifdef CLKDIV_BANK_TICK_EN
  logic [NUM_CH-1:0] tick_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) tick_q <= '0;
    else     tick_q <= clk_d & ~clk_q;
  end

  assign tick = tick_q;
`else
  assign tick = '0;
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomized and directed bench for clock_divider_bank against a phase-countdown reference model.
module tb_clock_divider_bank;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 8;
  localparam int RESET_HALF = 4;
  localparam int CH_W       = 2;
`ifdef CLKDIV_BANK_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif
  localparam int M_OFF = 0, M_ON = 1, M_DRAIN = 2;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  always #5 clk_sys = ~clk_sys;

  clock_divider_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(RESET_HALF)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .ch_en(ch_en), .sync(sync), .clk_out(clk_out),
    .tick(tick), .cfg_pending(cfg_pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel counts down the cycles left in its current phase.
  int m_act [NUM_CH];
  int m_shd [NUM_CH];
  int m_left[NUM_CH];
  int m_mode[NUM_CH];
  bit m_clk [NUM_CH];
  bit m_pend[NUM_CH];
  logic [NUM_CH-1:0] exp_clk, exp_pend, exp_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = RESET_HALF; m_shd[c] = RESET_HALF; m_left[c] = 0;
      m_mode[c] = M_OFF; m_clk[c] = 1'b0; m_pend[c] = 1'b0;
    end
    exp_clk = '0; exp_pend = '0; exp_tick = '0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] old_clk;
    old_clk = exp_clk;
    for (int c = 0; c < NUM_CH; c++) begin
      bit en, wr, new_phase;
      en = ch_en[c];
      wr = cfg_wr && (int'(cfg_ch) == c);
      new_phase = 1'b0;
      case (m_mode[c])
        M_OFF: if (en) begin m_mode[c] = M_ON; m_left[c] = m_act[c] + 1; end
        M_ON: begin
          if (sync) begin
            new_phase = 1'b1; m_clk[c] = 1'b0; m_mode[c] = en ? M_ON : M_OFF;
          end else if (!en && !m_clk[c]) begin
            new_phase = 1'b1; m_mode[c] = M_OFF;
          end else if (m_left[c] == 1) begin
            new_phase = 1'b1; m_clk[c] = !m_clk[c];
            if (!en) m_mode[c] = M_OFF;
          end else begin
            m_left[c]--;
            if (!en) m_mode[c] = M_DRAIN;
          end
        end
        default: begin
          if (m_left[c] == 1) begin
            new_phase = 1'b1; m_clk[c] = 1'b0; m_mode[c] = M_OFF;
          end else begin
            m_left[c]--;
          end
        end
      endcase
      if (new_phase && m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 1'b0; end
      if (new_phase) m_left[c] = m_act[c] + 1;
      if (wr) begin m_shd[c] = int'(cfg_half); m_pend[c] = 1'b1; end
      exp_clk[c]  = m_clk[c];
      exp_pend[c] = m_pend[c];
    end
    exp_tick = TICK_ON ? (exp_clk & ~old_clk) : '0;
  endtask

  task automatic compare();
    check_eq("clk_out", 32'(clk_out), 32'(exp_clk));
    check_eq("cfg_pending", 32'(cfg_pending), 32'(exp_pend));
    check_eq("tick", 32'(tick), 32'(exp_tick));
  endtask

  task automatic step_cycle();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    compare();
  endtask

  task automatic wait_rise(input int ch, input int budget, output int n);
    bit prev, done;
    n = -1; done = 1'b0;
    prev = clk_out[ch];
    for (int i = 1; i <= budget && !done; i++) begin
      step_cycle();
      if (!prev && clk_out[ch]) begin n = i; done = 1'b1; end
      prev = clk_out[ch];
    end
  endtask

  task automatic count_level(input int ch, input bit lvl, input int budget, output int n);
    bit done;
    n = 0; done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step_cycle();
      if (clk_out[ch] == lvl) n++;
      else done = 1'b1;
    end
  endtask

  task automatic write_cfg(input int ch, input int half);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(half);
    step_cycle();
    cfg_wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rise_at[NUM_CH];
    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0; ch_en = '0; sync = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check_eq("reset_clk_out", 32'(clk_out), 32'd0);
    check_eq("reset_pending", 32'(cfg_pending), 32'd0);
    check_eq("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    step_cycle();

    // Defaults on channel 0: first rise act+1 after the entry edge, then period 10.
    ch_en = 4'b0001;
    wait_rise(0, 20, n);
    check_eq("ch0_first_rise", 32'(n), 32'd6);
    check_eq("ch0_tick_at_rise", 32'(tick[0]), 32'(TICK_ON));
    wait_rise(0, 30, n);
    check_eq("ch0_period", 32'(n), 32'd10);
    check_eq("other_ch_low", 32'(clk_out[3:1]), 32'd0);

    // Channel 1: H=0 written while low, applied when dropping straight to IDLE.
    ch_en[1] = 1'b1;
    step_cycle(); step_cycle();
    write_cfg(1, 0);
    check_eq("ch1_pending_set", 32'(cfg_pending[1]), 32'd1);
    ch_en[1] = 1'b0;
    step_cycle();
    check_eq("ch1_pending_idle_clear", 32'(cfg_pending[1]), 32'd0);
    ch_en[1] = 1'b1;
    wait_rise(1, 10, n);
    check_eq("ch1_first_rise", 32'(n), 32'd2);
    wait_rise(1, 10, n);
    check_eq("ch1_period", 32'(n), 32'd2);

    // Mid-high-phase write of H=9 on channel 0 waits for the falling boundary.
    wait_rise(0, 30, n);
    write_cfg(0, 9);
    check_eq("ch0_pending_mid", 32'(cfg_pending[0]), 32'd1);
    count_level(0, 1'b1, 20, n);
    check_eq("ch0_high_old_rest", 32'(n), 32'd3);
    check_eq("ch0_pending_boundary_clear", 32'(cfg_pending[0]), 32'd0);
    count_level(0, 1'b0, 30, n);
    check_eq("ch0_low_new_rest", 32'(n), 32'd9);
    write_cfg(0, 4);
    count_level(0, 1'b1, 30, n);
    check_eq("ch0_high_new_rest", 32'(n), 32'd8);
    count_level(0, 1'b0, 30, n);
    check_eq("ch0_low_back_rest", 32'(n), 32'd4);

    // Drop enable two cycles into the high phase: drain out the phase then idle.
    step_cycle();
    ch_en[0] = 1'b0;
    count_level(0, 1'b1, 20, n);
    check_eq("ch0_drain_high", 32'(n), 32'd3);
    count_level(0, 1'b0, 8, n);
    check_eq("ch0_idle_low", 32'(n), 32'd8);
    ch_en[0] = 1'b1;
    wait_rise(0, 20, n);
    check_eq("ch0_restart", 32'(n), 32'd6);

    // All four channels realigned by sync with H=2..5.
    ch_en = 4'b1111;
    step_cycle(); step_cycle();
    for (int c = 0; c < NUM_CH; c++) write_cfg(c, c + 2);
    sync = 1'b1;
    step_cycle();
    sync = 1'b0;
    check_eq("sync_all_low", 32'(clk_out), 32'd0);
    for (int c = 0; c < NUM_CH; c++) rise_at[c] = 0;
    for (int i = 1; i <= 8; i++) begin
      step_cycle();
      for (int c = 0; c < NUM_CH; c++)
        if (rise_at[c] == 0 && clk_out[c]) rise_at[c] = i;
    end
    for (int c = 0; c < NUM_CH; c++) check_eq("sync_rise", 32'(rise_at[c]), 32'(c + 3));

    // Reset in the middle of a drain with a pending write on channel 2.
    write_cfg(2, 4);
    wait_rise(2, 20, n);
    ch_en[2] = 1'b0;
    step_cycle();
    write_cfg(2, 7);
    check_eq("ch2_pending_before_rst", 32'(cfg_pending[2]), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("async_rst_pending", 32'(cfg_pending), 32'd0);
    check_eq("async_rst_tick", 32'(tick), 32'd0);
    ch_en = 4'b0100;
    @(negedge clk_sys); @(negedge clk_sys);
    rst = 1'b0;
    wait_rise(2, 20, n);
    check_eq("ch2_rise_after_rst", 32'(n), 32'd6);
    wait_rise(2, 30, n);
    check_eq("ch2_period_after_rst", 32'(n), 32'd10);

    // Random traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk_sys);
        rst = 1'b0;
      end else begin
        for (int c = 0; c < NUM_CH; c++)
          if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
        cfg_wr   = ($urandom_range(0, 3) == 0);
        cfg_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
        cfg_half = CNT_W'($urandom_range(0, 6));
        sync     = ($urandom_range(0, 39) == 0);
        step_cycle();
      end
    end
    cfg_wr = 1'b0; sync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
